// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
//   Shared definitions for the LFSR/MISR self-test harnesses.
//   - state_t              : run-control FSM states
//   - clog2()              : ceiling log2, never less than 1 (usable as a width)
//   - lfsr_default_taps()  : maximal-length Fibonacci feedback masks, widths 3..16
//                            (mask bit i set means register bit i feeds the XOR)
// -----------------------------------------------------------------------------
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Result is clamped to 1 so a counter sized with it is never zero-width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic [15:0] lfsr_default_taps(input int width);
    case (width)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/bist_misr.sv
// -----------------------------------------------------------------------------
// bist_misr
//   Multiple-input signature register. On each enabled edge the register
//   shifts left with XOR feedback from the tapped bits, then the (zero-extended)
//   input word is XORed in. clr wins over en and empties the signature.
// Ports
//   clk  in   1      rising-edge clock
//   rst  in   1      asynchronous reset, active-high (clears signature)
//   clr  in   1      synchronous clear
//   en   in   1      capture enable; d is ignored when low
//   d    in   N_D    response word to compact
//   sig  out  W      current signature
// -----------------------------------------------------------------------------
module bist_misr #(
  parameter int             W    = 8,
  parameter int             N_D  = 2,
  parameter logic [W-1:0]   TAPS = 8'hB8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic [N_D-1:0] d,
  output logic [W-1:0]   sig
);

  logic [W-1:0] r_sig;
  logic [W-1:0] w_d_ext;
  logic         w_fb;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_d_ext          = '0;
    w_d_ext[N_D-1:0] = d;
  end

  assign w_fb = ^(r_sig & TAPS);

  // NOTE: clocked state uses non-blocking assignments only, so every register
  // sees the pre-edge value of every other register regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= '0;
    end else if (clr) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= {r_sig[W-2:0], w_fb} ^ w_d_ext;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/bist_lfsr_misr.sv
// -----------------------------------------------------------------------------
// bist_lfsr_misr
//   Self-test harness for a combinational (or short-pipeline) benchmark netlist.
//   A Fibonacci LFSR drives N_PAT pseudo-random vectors into the netlist, the
//   responses are compacted by a MISR, and the final signature is compared
//   with GOLDEN once the run is DONE.
//   Timeline: the edge that samples start is edge 0; pattern k is on pat_o
//   after edge k; its response is captured at edge k+1+RESP_LAT; done rises
//   at edge N_PAT+RESP_LAT together with the last capture.
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous reset, active-high
//   start      in   1       begin a run (honoured only in IDLE or DONE)
//   pat_o      out  N_IN    registered vector to netlist inputs
//   pat_valid  out  1       pat_o holds a pattern under test
//   resp_i     in   N_OUT   netlist outputs, RESP_LAT clocks behind pat_o
//   busy       out  1       run in progress (RUN or DRAIN)
//   done       out  1       run finished, held until next start
//   pass       out  1       done and signature equals GOLDEN
//   signature  out  MISR_W  current MISR contents
// -----------------------------------------------------------------------------
module bist_lfsr_misr
  import bist_pkg::*;
#(
  parameter int                N_IN      = 5,
  parameter int                N_OUT     = 2,
  parameter int                N_PAT     = 31,
  parameter int                RESP_LAT  = 0,
  parameter logic [N_IN-1:0]   LFSR_SEED = {{(N_IN-1){1'b0}}, 1'b1},
  parameter logic [N_IN-1:0]   LFSR_TAPS = N_IN'(lfsr_default_taps(N_IN)),
  parameter int                MISR_W    = 8,
  parameter logic [MISR_W-1:0] MISR_TAPS = 8'hB8,
  parameter logic [MISR_W-1:0] GOLDEN    = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   pat_o,
  output logic              pat_valid,
  input  logic [N_OUT-1:0]  resp_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  localparam int CNT_W = clog2(N_PAT + 1);
  // Value of the drain counter on the last DRAIN edge. Unused when
  // RESP_LAT is 0 because RUN then goes straight to DONE.
  localparam logic [1:0] DRAIN_LAST = 2'(RESP_LAT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_IN-1:0]  r_pat;
  logic             r_pat_valid;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_drain_cnt;
  logic             w_start_ok;
  logic             w_last_pat;
  logic             w_lfsr_fb;
  logic             w_cap_en;

  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
  // The edge that launches the final pattern's successor also closes the run.
  assign w_last_pat = (r_state == RUN) && (r_cnt == CNT_W'(N_PAT - 1));
  assign w_lfsr_fb  = ^(r_pat & LFSR_TAPS);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start)      w_state_nxt = RUN;
      RUN:        if (w_last_pat) w_state_nxt = (RESP_LAT == 0) ? DONE : DRAIN;
      DRAIN:      if (r_drain_cnt == DRAIN_LAST) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pattern generator and pattern counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat       <= LFSR_SEED;
      r_pat_valid <= 1'b0;
      r_cnt       <= '0;
    end else if (w_start_ok) begin
      r_pat       <= LFSR_SEED;
      r_pat_valid <= 1'b1;
      r_cnt       <= '0;
    end else if (r_state == RUN) begin
      r_pat <= {r_pat[N_IN-2:0], w_lfsr_fb};
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last_pat) r_pat_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_drain_cnt <= '0;
    else if (r_state == DRAIN)  r_drain_cnt <= r_drain_cnt + 2'd1;
    else                        r_drain_cnt <= '0;
  end

  // ---------------------------------------------------------------------------
  // Capture enable: pat_valid delayed to line up with the netlist's response
  // ---------------------------------------------------------------------------
  generate
    if (RESP_LAT == 0) begin : g_no_delay
      assign w_cap_en = r_pat_valid;
    end else begin : g_delay
      logic [RESP_LAT-1:0] r_vdly;
      // NOTE: the delay line is reset like any control register; a stale
      // valid left in it after a mid-run reset would corrupt the next signature.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vdly <= '0;
        end else begin
          r_vdly[0] <= r_pat_valid;
          for (int i = 1; i < RESP_LAT; i++) r_vdly[i] <= r_vdly[i-1];
        end
      end
      assign w_cap_en = r_vdly[RESP_LAT-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Response compaction
  // ---------------------------------------------------------------------------
  bist_misr #(
    .W    (MISR_W),
    .N_D  (N_OUT),
    .TAPS (MISR_TAPS)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (w_start_ok),
    .en  (w_cap_en),
    .d   (resp_i),
    .sig (signature)
  );

  assign pat_o     = r_pat;
  assign pat_valid = r_pat_valid;
  assign busy      = (r_state == RUN) || (r_state == DRAIN);
  assign done      = (r_state == DONE);
  assign pass      = done && (signature == GOLDEN);

endmodule
